// File: rtl/car_motion_pkg.sv
// Shared definitions for the elevator carriage: FSM state encoding,
// default floor index width and travel direction constants.
package car_motion_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MOVE = 2'd1,
      S_STOP = 2'd2,
      S_DOOR = 2'd3
   } state_t;

   localparam int FLOOR_W = 3;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/car_motion_if.sv
// Link between the call controller (master) and the carriage (slave).
// should_move/direction are level requests re-evaluated at every floor, not a
// valid/ready handshake; floor_reached is a single-cycle strobe with no backpressure.
interface car_motion_if #(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_W    = 3
);
   logic                  should_move;
   logic                  direction;
   logic [NUM_FLOORS-1:0] call_all;
   logic [FLOOR_W-1:0]    cur_floor;
   logic                  floor_reached;
   logic                  moving;
   logic                  move_dir;
   logic                  door_open;

   modport master (
      output should_move, direction, call_all,
      input  cur_floor, floor_reached, moving, move_dir, door_open
   );

   modport slave (
      input  should_move, direction, call_all,
      output cur_floor, floor_reached, moving, move_dir, door_open
   );
endinterface

// File: rtl/car_motion_cycle_timer.sv
// Loadable down-counter with a zero flag; times both floor travel and door dwell.
module car_motion_cycle_timer #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)                     cnt_d = load_val_i;
      else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low reset to a fixed value.
module register #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   q_q <= RST_VAL;
      else if (en_i) q_q <= d_i;
   end

   assign q_o = q_q;
endmodule

// File: rtl/car_motion.sv
// Carriage simulator: travels floor by floor on controller requests, stops at
// called floors, pulses floor_reached and holds the door open for a fixed time.
module car_motion
   import car_motion_pkg::*;
#(
   parameter int NUM_FLOORS    = 8,
   parameter int FLOOR_W       = 3,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 6,
   parameter int RESET_FLOOR   = 0
) (
   input  logic         clk,
   input  logic         reset,
   car_motion_if.slave  bus,
   output state_t       dbg_state_o
);
   localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

   state_t             state_q, state_d;
   logic               dir_q, dir_d;
   logic [FLOOR_W-1:0] cur_q, nf;
   logic               step;
   logic               t_load, t_dec, t_zero;
   logic [CNT_W-1:0]   t_load_val, t_cnt;

   function automatic logic step_ok(input logic dir, input logic [FLOOR_W-1:0] f);
      return (dir == DIR_UP) ? (f != TOP_FLOOR) : (f != '0);
   endfunction

   register #(.W(FLOOR_W), .RST_VAL(FLOOR_W'(RESET_FLOOR))) u_floor (
      .clk_i (clk),
      .rst_ni(reset),
      .en_i  (step),
      .d_i   (nf),
      .q_o   (cur_q)
   );

   car_motion_cycle_timer #(.W(CNT_W)) u_timer (
      .clk_i     (clk),
      .rst_ni    (reset),
      .load_i    (t_load),
      .load_val_i(t_load_val),
      .dec_i     (t_dec),
      .cnt_o     (t_cnt),
      .zero_o    (t_zero)
   );

   assign nf = (dir_q == DIR_UP) ? cur_q + FLOOR_W'(1) : cur_q - FLOOR_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         dir_q   <= DIR_DOWN;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      step       = 1'b0;
      t_load     = 1'b0;
      t_load_val = '0;
      t_dec      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.call_all[cur_q]) begin
               state_d = S_STOP;
            end else if (bus.should_move && step_ok(bus.direction, cur_q)) begin
               dir_d      = bus.direction;
               t_load     = 1'b1;
               t_load_val = TRAVEL_LOAD;
               state_d    = S_MOVE;
            end
         end
         S_MOVE: begin
            if (!t_zero) begin
               t_dec = 1'b1;
            end else begin
               // Floor boundary: the only point where requests are re-sampled.
               step = 1'b1;
               if (bus.call_all[nf]) begin
                  state_d = S_STOP;
               end else if (bus.should_move && bus.direction == dir_q && step_ok(dir_q, nf)) begin
                  t_load     = 1'b1;
                  t_load_val = TRAVEL_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_STOP: begin
            t_load     = 1'b1;
            t_load_val = DOOR_LOAD;
            state_d    = S_DOOR;
         end
         S_DOOR: begin
            // Timer still at its load value marks the first door cycle, where a
            // stale call bit from the register file is ignored.
            if (t_cnt != DOOR_LOAD && bus.call_all[cur_q]) state_d = S_STOP;
            else if (t_zero)                               state_d = S_IDLE;
            else                                           t_dec   = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cur_floor     = cur_q;
   assign bus.floor_reached = (state_q == S_STOP);
   assign bus.moving        = (state_q == S_MOVE);
   assign bus.door_open     = (state_q == S_DOOR);
   assign bus.move_dir      = dir_q;
   assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_car_motion.sv
// Directed scenarios plus random requests for car_motion, checked each cycle
// against an event-level model of the carriage (floor, phase, time left).
module tb_car_motion;
   import car_motion_pkg::*;

   localparam int NF = 8;
   localparam int TC = 4;
   localparam int DC = 6;
   localparam int M_IDLE = 0, M_MOVE = 1, M_STOP = 2, M_DOOR = 3;

   logic   clk = 1'b0;
   logic   reset = 1'b0;
   state_t dbg_state;
   int     checks = 0;
   int     errors = 0;

   int m_mode, m_floor, m_left, m_shown;
   bit m_dir;

   car_motion_if #(.NUM_FLOORS(NF), .FLOOR_W(3)) bus ();

   car_motion #(
      .NUM_FLOORS(NF), .FLOOR_W(3), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .RESET_FLOOR(0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_legal(input bit d, input int f);
      return d ? (f < NF - 1) : (f > 0);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_floor = 0; m_left = 0; m_shown = 0; m_dir = 1'b0;
   endtask

   // One edge of the carriage as the rules describe it, using the inputs
   // present at that edge.
   task automatic model_step();
      case (m_mode)
         M_IDLE: begin
            if (bus.call_all[m_floor]) m_mode = M_STOP;
            else if (bus.should_move && m_legal(bus.direction, m_floor)) begin
               m_dir = bus.direction; m_left = TC; m_mode = M_MOVE;
            end
         end
         M_MOVE: begin
            m_left--;
            if (m_left == 0) begin
               m_floor += m_dir ? 1 : -1;
               if (bus.call_all[m_floor]) m_mode = M_STOP;
               else if (bus.should_move && bus.direction == m_dir && m_legal(m_dir, m_floor)) m_left = TC;
               else m_mode = M_IDLE;
            end
         end
         M_STOP: begin
            m_mode = M_DOOR; m_shown = 1;
         end
         default: begin
            if (m_shown >= 2 && bus.call_all[m_floor]) m_mode = M_STOP;
            else if (m_shown == DC) m_mode = M_IDLE;
            else m_shown++;
         end
      endcase
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      chk({tag, ":floor"},  32'(bus.cur_floor),     32'(m_floor));
      chk({tag, ":reach"},  32'(bus.floor_reached), 32'(m_mode == M_STOP));
      chk({tag, ":moving"}, 32'(bus.moving),        32'(m_mode == M_MOVE));
      chk({tag, ":door"},   32'(bus.door_open),     32'(m_mode == M_DOOR));
      chk({tag, ":dir"},    32'(bus.move_dir),      32'(m_dir));
      // The call register file drops the serviced call on the strobe.
      if (m_mode == M_STOP) bus.call_all[m_floor] = 1'b0;
   endtask

   initial begin
      int g;
      bus.should_move = 1'b0;
      bus.direction   = 1'b0;
      bus.call_all    = '0;
      model_reset();

      // Reset values
      #1;
      chk("rst_floor",  32'(bus.cur_floor), 0);
      chk("rst_moving", 32'(bus.moving), 0);
      chk("rst_door",   32'(bus.door_open), 0);
      chk("rst_reach",  32'(bus.floor_reached), 0);
      chk("rst_dir",    32'(bus.move_dir), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Multi-floor travel 0 -> 3 with a call at 3
      bus.should_move = 1'b1; bus.direction = 1'b1; bus.call_all = 8'b0000_1000;
      for (int n = 1; n <= 13; n++) begin
         cycle("mf");
         if (n == 1)  chk("mf_start", 32'(bus.moving), 1);
         if (n == 4)  chk("mf_f0",    32'(bus.cur_floor), 0);
         if (n == 5)  chk("mf_f1",    32'(bus.cur_floor), 1);
         if (n == 9)  chk("mf_f2",    32'(bus.cur_floor), 2);
         if (n == 13) begin
            chk("mf_f3",    32'(bus.cur_floor), 3);
            chk("mf_reach", 32'(bus.floor_reached), 1);
         end
      end
      bus.should_move = 1'b0;
      for (int n = 1; n <= DC; n++) begin
         cycle("mf_door");
         chk("mf_door_open", 32'(bus.door_open), 1);
         chk("mf_no_reach",  32'(bus.floor_reached), 0);
      end
      cycle("mf_close");
      chk("mf_door_closed", 32'(bus.door_open), 0);

      // Boundary at top floor
      bus.should_move = 1'b1; bus.direction = 1'b1;
      g = 0;
      while (!(m_floor == NF - 1 && m_mode == M_IDLE) && g < 100) begin cycle("to_top"); g++; end
      chk("to_top_reached", 32'(m_floor == NF - 1 && m_mode == M_IDLE), 1);
      repeat (4) begin
         cycle("top_hold");
         chk("top_floor",  32'(bus.cur_floor), 7);
         chk("top_moving", 32'(bus.moving), 0);
      end

      // Boundary at bottom floor
      bus.direction = 1'b0;
      g = 0;
      while (!(m_floor == 0 && m_mode == M_IDLE) && g < 100) begin cycle("to_bot"); g++; end
      chk("to_bot_reached", 32'(m_floor == 0 && m_mode == M_IDLE), 1);
      repeat (4) begin
         cycle("bot_hold");
         chk("bot_floor",  32'(bus.cur_floor), 0);
         chk("bot_moving", 32'(bus.moving), 0);
      end

      // Park at floor 2
      bus.direction = 1'b1; bus.call_all = 8'b0000_0100;
      g = 0;
      while (m_mode != M_STOP && g < 50) begin cycle("to_2"); g++; end
      bus.should_move = 1'b0;
      g = 0;
      while (m_mode != M_IDLE && g < 50) begin cycle("park_2"); g++; end
      chk("park_2_floor", 32'(bus.cur_floor), 2);

      // Direction flip mid-floor
      bus.should_move = 1'b1; bus.direction = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         cycle("flip");
         if (n == 3) bus.direction = 1'b0;
         if (n == 4) chk("flip_midfloor", 32'(bus.cur_floor), 2);
         if (n == 5) begin
            chk("flip_arrive3", 32'(bus.cur_floor), 3);
            chk("flip_idle",    32'(bus.moving), 0);
         end
         if (n == 6) begin
            chk("flip_down_go",  32'(bus.moving), 1);
            chk("flip_down_dir", 32'(bus.move_dir), 0);
         end
      end
      bus.should_move = 1'b0;
      g = 0;
      while (m_mode != M_IDLE && g < 50) begin cycle("flip_settle"); g++; end

      // Call at current floor beats should_move in IDLE
      bus.call_all[m_floor] = 1'b1; bus.should_move = 1'b1; bus.direction = 1'b1;
      cycle("simul");
      chk("simul_reach",  32'(bus.floor_reached), 1);
      chk("simul_moving", 32'(bus.moving), 0);
      bus.should_move = 1'b0;
      g = 0;
      while (m_mode != M_IDLE && g < 50) begin cycle("simul_settle"); g++; end

      // Door reopen at floor 5
      bus.call_all[5] = 1'b1; bus.should_move = 1'b1; bus.direction = 1'b1;
      g = 0;
      while (m_mode != M_STOP && g < 50) begin cycle("to_5"); g++; end
      chk("at_5", 32'(bus.cur_floor), 5);
      bus.should_move = 1'b0;
      cycle("door1");
      chk("door1_open", 32'(bus.door_open), 1);
      bus.call_all[5] = 1'b1;
      cycle("door1_ignore");
      chk("door1_ignored", 32'(bus.floor_reached), 0);
      chk("door2_open",    32'(bus.door_open), 1);
      bus.call_all[5] = 1'b0;
      cycle("door3");
      bus.call_all[5] = 1'b1;
      cycle("reopen");
      chk("reopen_reach", 32'(bus.floor_reached), 1);
      for (int n = 1; n <= DC; n++) begin
         cycle("reopen_door");
         chk("reopen_door_open", 32'(bus.door_open), 1);
      end
      cycle("reopen_close");
      chk("reopen_closed", 32'(bus.door_open), 0);

      // Random requests and calls
      for (int i = 0; i < 400; i++) begin
         bus.should_move = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) bus.direction = ~bus.direction;
         if ($urandom_range(0, 9) == 0) bus.call_all[$urandom_range(0, NF - 1)] = 1'b1;
         cycle("rnd");
      end

      // Reset while travelling at floor 3
      bus.should_move = 1'b0; bus.call_all = '0;
      g = 0;
      while (m_mode != M_IDLE && g < 100) begin cycle("pre_rst"); g++; end
      bus.should_move = 1'b1;
      bus.direction = (m_floor <= 3);
      g = 0;
      while (!(m_floor == 3 && m_mode == M_MOVE) && g < 100) begin cycle("to_3"); g++; end
      chk("moving_at_3", 32'(bus.moving), 1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("arst_floor",  32'(bus.cur_floor), 0);
      chk("arst_moving", 32'(bus.moving), 0);
      chk("arst_door",   32'(bus.door_open), 0);
      chk("arst_reach",  32'(bus.floor_reached), 0);
      @(posedge clk);
      #1;
      chk("arst_hold_reach", 32'(bus.floor_reached), 0);
      chk("arst_hold_floor", 32'(bus.cur_floor), 0);
      bus.should_move = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) cycle("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
